regfile_rd: RTL and testbench
=============================

REGFILE_RD -- requirements
Module: regfile_rd

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count; AW = clog2(NREG).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset: asynchronous assert, active-low.
REQ-005 The block SHALL have ports we  input  1, waddr  input  AW, and wdata  input  XLEN, forming the write port.
REQ-006 The block SHALL have ports raddr1 / raddr2  input  AW, meaning read addresses.
REQ-007 The block SHALL have ports rdata1 / rdata2  output  XLEN, meaning combinational read data.
REQ-008 The block SHALL have port dump_start  input  1, a one-cycle request to stream out all registers.
REQ-009 The block SHALL have port dump_busy  output  1, high while a dump is in progress.
REQ-010 The block SHALL have ports dump_valid  output  1, dump_ready  input  1, dump_idx  output  AW, and dump_data  output  XLEN, forming the dump stream.

Function
REQ-011 Storage SHALL be NREG x XLEN flops; register 0 SHALL read as 0 and SHALL ignore writes.
REQ-012 On a clock edge with we=1 and waddr!=0, mem[waddr] SHALL take wdata.
REQ-013 rdata1 and rdata2 SHALL equal mem[raddr1] and mem[raddr2] combinationally, with zero latency.
REQ-014 The dump FSM SHALL have states IDLE and SEND.
REQ-015 In IDLE, dump_start=1 SHALL transition the FSM to SEND with dump_idx=0.
REQ-016 In SEND, dump_valid and dump_busy SHALL both be 1.
REQ-017 In SEND, a handshake (dump_valid & dump_ready) with dump_idx=NREG-1 SHALL transition the FSM to IDLE; any other handshake SHALL increment dump_idx.
REQ-018 dump_data SHALL be a registered snapshot loaded on the edge that loads dump_idx; it SHALL hold the post-edge value of the addressed register, so a write to that index on the same edge captures wdata.
REQ-019 dump_data and dump_idx SHALL stay stable while dump_valid=1 and dump_ready=0, even if that register is later written.
REQ-020 dump_start SHALL be ignored while the FSM is in SEND.
REQ-021 In IDLE, dump_valid and dump_busy SHALL be 0.
REQ-022 The write port SHALL remain fully functional during a dump.

Reset
REQ-023 rst_n=0 SHALL immediately clear all registers, return the FSM to IDLE, clear dump_idx and dump_data, and deassert dump_valid and dump_busy.
REQ-024 A reset asserted mid-dump SHALL abort the dump, and no further dump_valid SHALL appear until a new dump_start.

Configuration
REQ-025 With macro REGFILE_RD_BYPASS_EN defined, when we=1, waddr!=0 and waddr equals raddrN, rdataN SHALL return wdata in the same cycle (write-first).
REQ-026 Without REGFILE_RD_BYPASS_EN, rdataN SHALL return the stored old value until the edge after the write.

Structure
REQ-027 Package regfile_rd_pkg SHALL hold XLEN/NREG defaults, AW, and the dump_state_t enum {IDLE, SEND}.
REQ-028 The dump FSM and snapshot logic SHALL live in sub-module regfile_rd_dump; the storage and read muxes SHALL live in the top.

Verification
REQ-029 Write x5=0xDEADBEEF, then read raddr1=5 next cycle -> rdata1=0xDEADBEEF; write x0=0x1234 -> rdata2 with raddr2=0 reads 0.
REQ-030 Same-cycle write x7=0xA5A5A5A5 with raddr1=7 -> rdata1=0xA5A5A5A5 with REGFILE_RD_BYPASS_EN, old value 0 without.
REQ-031 Preload xi=i*0x11, pulse dump_start, hold dump_ready=1 -> 32 consecutive beats idx 0..31 with data i*0x11 (idx0=0), then dump_busy=0.
REQ-032 During a dump, drop dump_ready for 3 cycles at idx 4 and write x4=0xFFFF0000 -> idx and data stay 4 / 0x44 until the handshake; a second dump_start mid-dump is ignored.
REQ-033 Assert rst_n=0 at idx 10 mid-dump -> dump_valid=0 and all registers read 0 without waiting for a clock edge; no beats appear after reset release.

Source files
------------

// File: rtl/regfile_rd_pkg.sv
// Shared defaults and dump-FSM state encoding for the regfile_rd slice.
package regfile_rd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_rd_dump.sv
// Dump sequencer: streams registers 0..NREG-1 as idx/data beats. Snapshot is
// registered with the index; beats hold stable while dump_ready is low.
module regfile_rd_dump
  import regfile_rd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic            dump_ready,
  input  logic [XLEN-1:0] snap_data,
  output logic [AW-1:0]   snap_addr,
  output logic            dump_busy,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  dump_state_t     state, state_nxt;
  logic [AW-1:0]   idx_nxt;
  logic            load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      state    <= state_nxt;
      dump_idx <= idx_nxt;
      if (load) dump_data <= snap_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = dump_idx;
    load       = 1'b0;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (dump_idx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt = dump_idx + AW'(1);
            load    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The top resolves the post-edge value of the index about to be loaded.
  assign snap_addr = idx_nxt;

endmodule

// File: rtl/regfile_rd.sv
// Register file: 1 write port, 2 zero-latency read ports, x0 hardwired to 0, plus dump stream.
// Optional write-first read bypass under REGFILE_RD_BYPASS_EN; dump beats stall on dump_ready.
module regfile_rd
  import regfile_rd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            dump_start,
  output logic            dump_busy,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data
);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_en;
  logic [AW-1:0]   snap_addr;
  logic [XLEN-1:0] snap_data;

  assign wr_en = we && (waddr != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
`ifdef REGFILE_RD_BYPASS_EN
    if (wr_en && (waddr == raddr1)) rdata1 = wdata;
    if (wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

  // Snapshot source is the value the addressed register holds after this edge.
  assign snap_data = (snap_addr == '0)               ? '0    :
                     (wr_en && (waddr == snap_addr)) ? wdata :
                                                       mem[snap_addr];

  regfile_rd_dump #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .snap_data  (snap_data),
    .snap_addr  (snap_addr),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

endmodule

// File: tb/tb_regfile_rd.sv
// Directed bench for regfile_rd: reads, x0, bypass, full dump, stalled dump, reset mid-dump.
// Dump beats are predicted into a queue and compared as handshakes occur.
module tb_regfile_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        dump_start, dump_busy, dump_valid, dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       sbq[$];
  beat_t       mon_b;
  logic [31:0] tb_mem [32];
  int          errors = 0;
  int          checks = 0;
  int          cnt;

  always #5 clk = ~clk;

  regfile_rd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input int n);
    for (int i = 0; i < n; i++) sbq.push_back({5'(i), tb_mem[i]});
  endtask

  // Scoreboard: every handshake must match the next predicted beat.
  always @(negedge clk) begin
    if (dump_valid && dump_ready) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed idx=%0d data=%0h expected=no beat", dump_idx, dump_data);
      end
      if (sbq.size() != 0) begin
        mon_b = sbq.pop_front();
        chk("beat_idx", 64'(dump_idx), 64'(mon_b.idx));
        chk("beat_data", 64'(dump_data), 64'(mon_b.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = '0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd3; raddr2 = 5'd31; dump_start = 1'b0; dump_ready = 1'b0;
    #3;
    chk("rst_valid", 64'(dump_valid), 64'd0);
    chk("rst_busy", 64'(dump_busy), 64'd0);
    chk("rst_idx", 64'(dump_idx), 64'd0);
    chk("rst_data", 64'(dump_data), 64'd0);
    chk("rst_rdata1", 64'(rdata1), 64'd0);
    chk("rst_rdata2", 64'(rdata2), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // x5 write then read next cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
    step();
    we = 1'b0;
    @(negedge clk);
    chk("x5_read", 64'(rdata1), 64'hDEADBEEF);

    // x0 ignores writes and never bypasses
    step();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr2 = 5'd0;
    @(negedge clk);
    chk("x0_same_cycle", 64'(rdata2), 64'd0);
    step();
    we = 1'b0;
    @(negedge clk);
    chk("x0_after", 64'(rdata2), 64'd0);

    // same-cycle x7 write
    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7;
    @(negedge clk);
`ifdef REGFILE_RD_BYPASS_EN
    chk("x7_same_cycle", 64'(rdata1), 64'hA5A5A5A5);
`else
    chk("x7_same_cycle", 64'(rdata1), 64'd0);
`endif
    step();
    we = 1'b0;
    @(negedge clk);
    chk("x7_after", 64'(rdata1), 64'hA5A5A5A5);

    // preload xi = i*0x11
    step();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i * 17); tb_mem[i] = 32'(i * 17);
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      chk("preload_r1", 64'(rdata1), 64'(tb_mem[i]));
      chk("preload_r2", 64'(rdata2), 64'(tb_mem[31 - i]));
    end

    // full dump with dump_ready held high
    step();
    push_all(32);
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!dump_busy) break;
      cnt++;
    end
    chk("dump1_busy_cycles", 64'(cnt), 64'd32);
    chk("dump1_busy_end", 64'(dump_busy), 64'd0);
    chk("dump1_valid_end", 64'(dump_valid), 64'd0);
    chk("dump1_drained", 64'(sbq.size()), 64'd0);

    // stalled dump: stall at idx 4, overwrite x4, second start ignored
    step();
    push_all(32);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (dump_idx == 5'd4) break;
      step();
    end
    chk("dump2_reach_idx4", 64'(dump_idx), 64'd4);
    dump_ready = 1'b0; we = 1'b1; waddr = 5'd4; wdata = 32'hFFFF0000; dump_start = 1'b1;
    tb_mem[4] = 32'hFFFF0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_idx", 64'(dump_idx), 64'd4);
      chk("stall_data", 64'(dump_data), 64'h44);
      chk("stall_valid", 64'(dump_valid), 64'd1);
      step();
      we = 1'b0; dump_start = 1'b0;
    end
    dump_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!dump_busy) break;
    end
    chk("dump2_busy_end", 64'(dump_busy), 64'd0);
    chk("dump2_drained", 64'(sbq.size()), 64'd0);
    raddr1 = 5'd4;
    #1;
    chk("x4_written_during_dump", 64'(rdata1), 64'hFFFF0000);
    for (int k = 0; k < 5; k++) step();
    chk("dump2_no_restart", 64'(dump_busy), 64'd0);

    // reset asserted mid-dump at idx 10
    push_all(10);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (dump_idx == 5'd10) break;
      step();
    end
    chk("dump3_reach_idx10", 64'(dump_idx), 64'd10);
    chk("dump3_data_idx10", 64'(dump_data), 64'hAA);
    rst_n = 1'b0;
    raddr1 = 5'd5; raddr2 = 5'd31;
    #1;
    chk("midrst_valid", 64'(dump_valid), 64'd0);
    chk("midrst_busy", 64'(dump_busy), 64'd0);
    chk("midrst_idx", 64'(dump_idx), 64'd0);
    chk("midrst_data", 64'(dump_data), 64'd0);
    chk("midrst_r1", 64'(rdata1), 64'd0);
    chk("midrst_r2", 64'(rdata2), 64'd0);
    chk("midrst_drained", 64'(sbq.size()), 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step();
    chk("post_rst_busy", 64'(dump_busy), 64'd0);
    chk("post_rst_valid", 64'(dump_valid), 64'd0);
    raddr1 = 5'd17;
    #1;
    chk("post_rst_r1", 64'(rdata1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
